// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: shares one 512-bit AXI4 port between N_PORTS requesters.
// AW and AR are granted round-robin through registered output stages.
// W beats follow AW grant order through a small FIFO of requester indices.
// B and R responses are steered back by a tag carried in ID bits [15:14].
module axi_rr_arbiter #(
  parameter int N_PORTS     = 2,
  parameter int WFIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // requester side
  input  logic [N_PORTS*16-1:0]  s_awid,
  input  logic [N_PORTS*64-1:0]  s_awaddr,
  input  logic [N_PORTS*8-1:0]   s_awlen,
  input  logic [N_PORTS*3-1:0]   s_awsize,
  input  logic [N_PORTS-1:0]     s_awvalid,
  output logic [N_PORTS-1:0]     s_awready,
  input  logic [N_PORTS*512-1:0] s_wdata,
  input  logic [N_PORTS*64-1:0]  s_wstrb,
  input  logic [N_PORTS-1:0]     s_wlast,
  input  logic [N_PORTS-1:0]     s_wvalid,
  output logic [N_PORTS-1:0]     s_wready,
  output logic [N_PORTS*16-1:0]  s_bid,
  output logic [N_PORTS*2-1:0]   s_bresp,
  output logic [N_PORTS-1:0]     s_bvalid,
  input  logic [N_PORTS-1:0]     s_bready,
  input  logic [N_PORTS*16-1:0]  s_arid,
  input  logic [N_PORTS*64-1:0]  s_araddr,
  input  logic [N_PORTS*8-1:0]   s_arlen,
  input  logic [N_PORTS*3-1:0]   s_arsize,
  input  logic [N_PORTS-1:0]     s_arvalid,
  output logic [N_PORTS-1:0]     s_arready,
  output logic [N_PORTS*16-1:0]  s_rid,
  output logic [N_PORTS*512-1:0] s_rdata,
  output logic [N_PORTS*2-1:0]   s_rresp,
  output logic [N_PORTS-1:0]     s_rlast,
  output logic [N_PORTS-1:0]     s_rvalid,
  input  logic [N_PORTS-1:0]     s_rready,
  // shared port side
  output logic [15:0]            m_awid,
  output logic [63:0]            m_awaddr,
  output logic [7:0]             m_awlen,
  output logic [2:0]             m_awsize,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [511:0]           m_wdata,
  output logic [63:0]            m_wstrb,
  output logic                   m_wlast,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  input  logic [15:0]            m_bid,
  input  logic [1:0]             m_bresp,
  input  logic                   m_bvalid,
  output logic                   m_bready,
  output logic [15:0]            m_arid,
  output logic [63:0]            m_araddr,
  output logic [7:0]             m_arlen,
  output logic [2:0]             m_arsize,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  input  logic [15:0]            m_rid,
  input  logic [511:0]           m_rdata,
  input  logic [1:0]             m_rresp,
  input  logic                   m_rlast,
  input  logic                   m_rvalid,
  output logic                   m_rready
);

  localparam int FAW = $clog2(WFIFO_DEPTH);
  localparam logic [FAW:0] FIFO_FULL_CNT = (FAW+1)'(WFIFO_DEPTH);

  typedef enum logic {AW_IDLE, AW_BUSY} aw_state_e;
  typedef enum logic {AR_IDLE, AR_BUSY} ar_state_e;

  // First requesting port at or after ptr, wrapping; returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [N_PORTS-1:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    int idx;
    res = '0;
    for (int i = N_PORTS-1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (req[idx]) res = {1'b1, idx[1:0]};
    end
    return res;
  endfunction

  aw_state_e    aw_state_q, aw_state_d;
  logic [1:0]   aw_ptr_q, aw_ptr_d;
  logic [15:0]  aw_id_q, aw_id_d;
  logic [63:0]  aw_addr_q, aw_addr_d;
  logic [7:0]   aw_len_q, aw_len_d;
  logic [2:0]   aw_size_q, aw_size_d;
  logic [2:0]   aw_pick;
  logic [1:0]   aw_win;
  logic         aw_push;
  int           aw_nxt;

  ar_state_e    ar_state_q, ar_state_d;
  logic [1:0]   ar_ptr_q, ar_ptr_d;
  logic [15:0]  ar_id_q, ar_id_d;
  logic [63:0]  ar_addr_q, ar_addr_d;
  logic [7:0]   ar_len_q, ar_len_d;
  logic [2:0]   ar_size_q, ar_size_d;
  logic [2:0]   ar_pick;
  logic [1:0]   ar_win;
  int           ar_nxt;

  logic [1:0]     wfifo_mem_q [WFIFO_DEPTH];
  logic [FAW-1:0] wfifo_wr_q, wfifo_wr_d;
  logic [FAW-1:0] wfifo_rd_q, wfifo_rd_d;
  logic [FAW:0]   wfifo_cnt_q, wfifo_cnt_d;
  logic           wfifo_full, wfifo_empty, w_pop;
  logic [1:0]     w_head;
  logic           unused_tag_bits;

  assign wfifo_full  = (wfifo_cnt_q == FIFO_FULL_CNT);
  assign wfifo_empty = (wfifo_cnt_q == '0);
  assign w_head      = wfifo_mem_q[wfifo_rd_q];

  assign m_awvalid = (aw_state_q == AW_BUSY);
  assign m_awid    = aw_id_q;
  assign m_awaddr  = aw_addr_q;
  assign m_awlen   = aw_len_q;
  assign m_awsize  = aw_size_q;

  assign m_arvalid = (ar_state_q == AR_BUSY);
  assign m_arid    = ar_id_q;
  assign m_araddr  = ar_addr_q;
  assign m_arlen   = ar_len_q;
  assign m_arsize  = ar_size_q;

  assign s_bid   = {N_PORTS{{2'b00, m_bid[13:0]}}};
  assign s_bresp = {N_PORTS{m_bresp}};
  assign s_rid   = {N_PORTS{{2'b00, m_rid[13:0]}}};
  assign s_rdata = {N_PORTS{m_rdata}};
  assign s_rresp = {N_PORTS{m_rresp}};
  assign s_rlast = {N_PORTS{m_rlast}};

  // Requester ID bits [15:14] are replaced by the tag; fold them so they are consumed.
  always_comb begin
    unused_tag_bits = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      unused_tag_bits = unused_tag_bits ^ (^s_awid[i*16+14 +: 2]) ^ (^s_arid[i*16+14 +: 2]);
    end
  end

  // AW arbitration: grant in IDLE when the W order FIFO has room, then hold the beat in BUSY.
  always_comb begin
    aw_state_d = aw_state_q;
    aw_ptr_d   = aw_ptr_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    s_awready  = '0;
    aw_push    = 1'b0;
    aw_pick    = rr_pick(s_awvalid, aw_ptr_q);
    aw_win     = aw_pick[1:0];
    aw_nxt     = 0;
    case (aw_state_q)
      AW_IDLE: begin
        if (rst_n && aw_pick[2] && !wfifo_full) begin
          aw_push    = 1'b1;
          aw_state_d = AW_BUSY;
          aw_nxt     = int'(aw_win) + 1;
          if (aw_nxt >= N_PORTS) aw_nxt = 0;
          aw_ptr_d = aw_nxt[1:0];
          for (int i = 0; i < N_PORTS; i++) begin
            if (i == int'(aw_win)) begin
              s_awready[i] = 1'b1;
              aw_id_d      = {aw_win, s_awid[i*16 +: 14]};
              aw_addr_d    = s_awaddr[i*64 +: 64];
              aw_len_d     = s_awlen[i*8 +: 8];
              aw_size_d    = s_awsize[i*3 +: 3];
            end
          end
        end
      end
      default: begin
        if (m_awready) aw_state_d = AW_IDLE;
      end
    endcase
  end

  // AW state, pointer and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_state_q <= AW_IDLE;
      aw_ptr_q   <= '0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
    end else begin
      aw_state_q <= aw_state_d;
      aw_ptr_q   <= aw_ptr_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
    end
  end

  // AR arbitration: same shape as AW but with no dependency on the W path.
  always_comb begin
    ar_state_d = ar_state_q;
    ar_ptr_d   = ar_ptr_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    s_arready  = '0;
    ar_pick    = rr_pick(s_arvalid, ar_ptr_q);
    ar_win     = ar_pick[1:0];
    ar_nxt     = 0;
    case (ar_state_q)
      AR_IDLE: begin
        if (rst_n && ar_pick[2]) begin
          ar_state_d = AR_BUSY;
          ar_nxt     = int'(ar_win) + 1;
          if (ar_nxt >= N_PORTS) ar_nxt = 0;
          ar_ptr_d = ar_nxt[1:0];
          for (int i = 0; i < N_PORTS; i++) begin
            if (i == int'(ar_win)) begin
              s_arready[i] = 1'b1;
              ar_id_d      = {ar_win, s_arid[i*16 +: 14]};
              ar_addr_d    = s_araddr[i*64 +: 64];
              ar_len_d     = s_arlen[i*8 +: 8];
              ar_size_d    = s_arsize[i*3 +: 3];
            end
          end
        end
      end
      default: begin
        if (m_arready) ar_state_d = AR_IDLE;
      end
    endcase
  end

  // AR state, pointer and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_state_q <= AR_IDLE;
      ar_ptr_q   <= '0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
    end else begin
      ar_state_q <= ar_state_d;
      ar_ptr_q   <= ar_ptr_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
    end
  end

  // W mux: only the requester at the FIFO head sees m_wready; nothing flows when empty.
  always_comb begin
    m_wdata  = '0;
    m_wstrb  = '0;
    m_wlast  = 1'b0;
    m_wvalid = 1'b0;
    s_wready = '0;
    if (!wfifo_empty) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (i == int'(w_head)) begin
          m_wdata     = s_wdata[i*512 +: 512];
          m_wstrb     = s_wstrb[i*64 +: 64];
          m_wlast     = s_wlast[i];
          m_wvalid    = s_wvalid[i];
          s_wready[i] = m_wready;
        end
      end
    end
  end

  // W order FIFO bookkeeping; a push and a pop together leave the count alone.
  always_comb begin
    w_pop       = m_wvalid & m_wready & m_wlast;
    wfifo_wr_d  = wfifo_wr_q;
    wfifo_rd_d  = wfifo_rd_q;
    wfifo_cnt_d = wfifo_cnt_q;
    if (aw_push) wfifo_wr_d = wfifo_wr_q + 1'b1;
    if (w_pop)   wfifo_rd_d = wfifo_rd_q + 1'b1;
    if (aw_push && !w_pop)      wfifo_cnt_d = wfifo_cnt_q + 1'b1;
    else if (w_pop && !aw_push) wfifo_cnt_d = wfifo_cnt_q - 1'b1;
  end

  // W order FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wfifo_wr_q  <= '0;
      wfifo_rd_q  <= '0;
      wfifo_cnt_q <= '0;
    end else begin
      wfifo_wr_q  <= wfifo_wr_d;
      wfifo_rd_q  <= wfifo_rd_d;
      wfifo_cnt_q <= wfifo_cnt_d;
    end
  end

  // W order FIFO storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (aw_push) wfifo_mem_q[wfifo_wr_q] <= aw_win;
  end

  // B routing by tag; an out-of-range tag is drained so the slave never stalls.
  always_comb begin
    s_bvalid = '0;
    m_bready = 1'b1;
    for (int i = 0; i < N_PORTS; i++) begin
      if (i == int'(m_bid[15:14])) begin
        s_bvalid[i] = m_bvalid & rst_n;
        m_bready    = s_bready[i];
      end
    end
  end

  // R routing by tag, beat by beat, so bursts of different IDs may interleave.
  always_comb begin
    s_rvalid = '0;
    m_rready = 1'b1;
    for (int i = 0; i < N_PORTS; i++) begin
      if (i == int'(m_rid[15:14])) begin
        s_rvalid[i] = m_rvalid & rst_n;
        m_rready    = s_rready[i];
      end
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed self-checking bench for axi_rr_arbiter with two requesters.
module tb_axi_rr_arbiter;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*16-1:0]  s_awid;
  logic [N*64-1:0]  s_awaddr;
  logic [N*8-1:0]   s_awlen;
  logic [N*3-1:0]   s_awsize;
  logic [N-1:0]     s_awvalid, s_awready;
  logic [N*512-1:0] s_wdata;
  logic [N*64-1:0]  s_wstrb;
  logic [N-1:0]     s_wlast, s_wvalid, s_wready;
  logic [N*16-1:0]  s_bid;
  logic [N*2-1:0]   s_bresp;
  logic [N-1:0]     s_bvalid, s_bready;
  logic [N*16-1:0]  s_arid;
  logic [N*64-1:0]  s_araddr;
  logic [N*8-1:0]   s_arlen;
  logic [N*3-1:0]   s_arsize;
  logic [N-1:0]     s_arvalid, s_arready;
  logic [N*16-1:0]  s_rid;
  logic [N*512-1:0] s_rdata;
  logic [N*2-1:0]   s_rresp;
  logic [N-1:0]     s_rlast, s_rvalid, s_rready;
  logic [15:0]  m_awid;
  logic [63:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic         m_awvalid, m_awready;
  logic [511:0] m_wdata;
  logic [63:0]  m_wstrb;
  logic         m_wlast, m_wvalid, m_wready;
  logic [15:0]  m_bid;
  logic [1:0]   m_bresp;
  logic         m_bvalid, m_bready;
  logic [15:0]  m_arid;
  logic [63:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize;
  logic         m_arvalid, m_arready;
  logic [15:0]  m_rid;
  logic [511:0] m_rdata;
  logic [1:0]   m_rresp;
  logic         m_rlast, m_rvalid, m_rready;

  int errors;
  int checks;

  axi_rr_arbiter #(.N_PORTS(N), .WFIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Last-resort guard so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awvalid = '0;
    s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0;
    s_bready = '0; s_rready = '0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arvalid = '0;
    m_awready = 1'b1; m_wready = 1'b0; m_arready = 1'b1;
    m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    applyStimulus();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic driveAw(input int p, input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len);
    s_awid[p*16 +: 16]   = id;
    s_awaddr[p*64 +: 64] = addr;
    s_awlen[p*8 +: 8]    = len;
    s_awsize[p*3 +: 3]   = 3'd6;
  endtask

  task automatic driveAr(input int p, input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len);
    s_arid[p*16 +: 16]   = id;
    s_araddr[p*64 +: 64] = addr;
    s_arlen[p*8 +: 8]    = len;
    s_arsize[p*3 +: 3]   = 3'd6;
  endtask

  task automatic driveW(input int p, input logic [31:0] data, input logic last);
    s_wdata[p*512 +: 512] = {480'h0, data};
    s_wstrb[p*64 +: 64]   = '1;
    s_wlast[p]            = last;
    s_wvalid[p]           = 1'b1;
  endtask

  initial begin
    logic [1:0]  order [4];
    logic [63:0] addrs [4];
    logic [1:0]  exp_order [4];
    logic [63:0] exp_addr [4];
    int n, k, acc;

    errors = 0;
    checks = 0;
    exp_order = '{2'd0, 2'd1, 2'd0, 2'd1};
    exp_addr  = '{64'h2000, 64'h3000, 64'h2000, 64'h3000};

    // Reset state, with a request pending that must not be acknowledged.
    rst_n = 1'b0;
    applyStimulus();
    s_awvalid = 2'b01;
    s_arvalid = 2'b10;
    tick();
    tick();
    checkOutput("rst_awvalid", 64'(m_awvalid), 64'h0);
    checkOutput("rst_arvalid", 64'(m_arvalid), 64'h0);
    checkOutput("rst_awready", 64'(s_awready), 64'h0);
    checkOutput("rst_arready", 64'(s_arready), 64'h0);
    checkOutput("rst_wready", 64'(s_wready), 64'h0);
    checkOutput("rst_wvalid", 64'(m_wvalid), 64'h0);
    checkOutput("rst_awaddr", m_awaddr, 64'h0);
    s_awvalid = '0;
    s_arvalid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single port 0 write: AW, four W beats, then a B response.
    driveAw(0, 16'h0007, 64'h1000, 8'd3);
    s_awvalid = 2'b01;
    #1;
    checkOutput("t1_awready", 64'(s_awready), 64'h1);
    tick();
    s_awvalid = '0;
    #1;
    checkOutput("t1_m_awvalid", 64'(m_awvalid), 64'h1);
    checkOutput("t1_m_awaddr", m_awaddr, 64'h1000);
    checkOutput("t1_m_awid", 64'(m_awid), 64'h0007);
    checkOutput("t1_m_awlen", 64'(m_awlen), 64'h3);
    tick();
    checkOutput("t1_aw_done", 64'(m_awvalid), 64'h0);
    m_wready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      driveW(0, 32'hA0 + 32'(b), (b == 3));
      #1;
      checkOutput("t1_wready", 64'(s_wready), 64'h1);
      checkOutput("t1_wdata", 64'(m_wdata[31:0]), 64'hA0 + 64'(b));
      checkOutput("t1_wlast", 64'(m_wlast), (b == 3) ? 64'h1 : 64'h0);
      tick();
    end
    #1;
    checkOutput("t1_fifo_empty_rdy", 64'(s_wready), 64'h0);
    checkOutput("t1_fifo_empty_vld", 64'(m_wvalid), 64'h0);
    s_wvalid = '0;
    m_wready = 1'b0;
    m_bid = 16'h0005;
    m_bvalid = 1'b1;
    s_bready = 2'b01;
    #1;
    checkOutput("t1_bvalid", 64'(s_bvalid), 64'h1);
    checkOutput("t1_bid", 64'(s_bid[15:0]), 64'h0005);
    checkOutput("t1_bready", 64'(m_bready), 64'h1);
    m_bid = 16'h4005;
    #1;
    checkOutput("t1_bvalid_p1", 64'(s_bvalid), 64'h2);
    checkOutput("t1_bid_p1", 64'(s_bid[31:16]), 64'h0005);
    checkOutput("t1_bready_p1", 64'(m_bready), 64'h0);
    m_bvalid = 1'b0;
    tick();

    // Two ports requesting AW every cycle: grants alternate starting at port 0.
    doReset();
    driveAw(0, 16'h0001, 64'h2000, 8'd1);
    driveAw(1, 16'h0002, 64'h3000, 8'd0);
    s_awvalid = 2'b11;
    n = 0;
    k = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      #1;
      if (m_awvalid) begin
        order[n] = m_awid[15:14];
        addrs[n] = m_awaddr;
        n++;
      end
      if (s_awready != '0) k++;
      tick();
      if (k == 4) s_awvalid = '0;
    end
    checkOutput("t2_grant_count", 64'(n), 64'h4);
    for (int i = 0; i < n; i++) begin
      checkOutput("t2_grant_tag", 64'(order[i]), 64'(exp_order[i]));
      checkOutput("t2_grant_addr", addrs[i], exp_addr[i]);
    end
    // W data follows grant order 0,1,0,1; port 1 waits for port 0's last beat.
    m_wready = 1'b1;
    driveW(0, 32'hB0, 1'b0);
    driveW(1, 32'hC0, 1'b1);
    #1;
    checkOutput("t2_w0a_rdy", 64'(s_wready), 64'h1);
    checkOutput("t2_w0a_data", 64'(m_wdata[31:0]), 64'hB0);
    tick();
    driveW(0, 32'hB1, 1'b1);
    #1;
    checkOutput("t2_w0b_rdy", 64'(s_wready), 64'h1);
    checkOutput("t2_w0b_last", 64'(m_wlast), 64'h1);
    tick();
    #1;
    checkOutput("t2_w1_rdy", 64'(s_wready), 64'h2);
    checkOutput("t2_w1_data", 64'(m_wdata[31:0]), 64'hC0);
    tick();
    #1;
    checkOutput("t2_w0c_rdy", 64'(s_wready), 64'h1);
    tick();
    #1;
    checkOutput("t2_w1b_rdy", 64'(s_wready), 64'h2);
    tick();
    #1;
    checkOutput("t2_w_empty_rdy", 64'(s_wready), 64'h0);
    checkOutput("t2_w_empty_vld", 64'(m_wvalid), 64'h0);
    s_wvalid = '0;
    m_wready = 1'b0;

    // W order FIFO fills at 8 grants; the 9th waits for a W pop.
    doReset();
    m_wready = 1'b0;
    driveAw(0, 16'h0003, 64'h4000, 8'd0);
    s_awvalid = 2'b01;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (s_awready[0]) acc++;
      tick();
    end
    checkOutput("t3_accepted", 64'(acc), 64'h8);
    #1;
    checkOutput("t3_stall", 64'(s_awready), 64'h0);
    checkOutput("t3_busy_done", 64'(m_awvalid), 64'h0);
    driveW(0, 32'hD0, 1'b1);
    m_wready = 1'b1;
    #1;
    checkOutput("t3_pop_cycle_awrdy", 64'(s_awready), 64'h0);
    checkOutput("t3_pop_wready", 64'(s_wready), 64'h1);
    tick();
    s_wvalid = '0;
    m_wready = 1'b0;
    #1;
    checkOutput("t3_ninth", 64'(s_awready), 64'h1);
    tick();
    s_awvalid = '0;
    #1;
    checkOutput("t3_ninth_out", 64'(m_awvalid), 64'h1);
    tick();

    // AR from port 1 and its two-beat read response.
    driveAr(1, 16'h0002, 64'h8000, 8'd1);
    s_arvalid = 2'b10;
    #1;
    checkOutput("t4_arready", 64'(s_arready), 64'h2);
    tick();
    s_arvalid = '0;
    #1;
    checkOutput("t4_m_arvalid", 64'(m_arvalid), 64'h1);
    checkOutput("t4_m_arid", 64'(m_arid), 64'h4002);
    checkOutput("t4_m_arlen", 64'(m_arlen), 64'h1);
    checkOutput("t4_m_araddr", m_araddr, 64'h8000);
    tick();
    checkOutput("t4_ar_done", 64'(m_arvalid), 64'h0);
    s_rready = 2'b11;
    m_rvalid = 1'b1;
    m_rid = 16'h4002;
    m_rdata = {480'h0, 32'hE0};
    m_rlast = 1'b0;
    #1;
    checkOutput("t4_r1_valid", 64'(s_rvalid), 64'h2);
    checkOutput("t4_r1_rid", 64'(s_rid[31:16]), 64'h0002);
    checkOutput("t4_r1_last", 64'(s_rlast[1]), 64'h0);
    checkOutput("t4_r1_data", 64'(s_rdata[512 +: 32]), 64'hE0);
    checkOutput("t4_r1_ready", 64'(m_rready), 64'h1);
    tick();
    m_rdata = {480'h0, 32'hE1};
    m_rlast = 1'b1;
    #1;
    checkOutput("t4_r2_valid", 64'(s_rvalid), 64'h2);
    checkOutput("t4_r2_last", 64'(s_rlast[1]), 64'h1);
    tick();

    // Interleaved R beats with port 1 not ready: port 0 passes, port 1 is held.
    s_rready = 2'b01;
    m_rlast = 1'b0;
    m_rid = 16'h0001;
    m_rdata = {480'h0, 32'hF0};
    #1;
    checkOutput("t5_p0_valid", 64'(s_rvalid), 64'h1);
    checkOutput("t5_p0_ready", 64'(m_rready), 64'h1);
    checkOutput("t5_p0_data", 64'(s_rdata[31:0]), 64'hF0);
    tick();
    m_rid = 16'h4001;
    m_rdata = {480'h0, 32'hF1};
    #1;
    checkOutput("t5_p1_valid", 64'(s_rvalid), 64'h2);
    checkOutput("t5_p1_ready", 64'(m_rready), 64'h0);
    tick();
    #1;
    checkOutput("t5_p1_hold", 64'(m_rready), 64'h0);
    tick();
    m_rid = 16'h0001;
    m_rdata = {480'h0, 32'hF2};
    #1;
    checkOutput("t5_p0b_valid", 64'(s_rvalid), 64'h1);
    checkOutput("t5_p0b_ready", 64'(m_rready), 64'h1);
    tick();
    m_rvalid = 1'b0;
    s_rready = '0;

    // Reset in the middle of a W burst.
    doReset();
    m_awready = 1'b0;
    driveAw(0, 16'h0009, 64'h5000, 8'd3);
    s_awvalid = 2'b01;
    #1;
    tick();
    s_awvalid = '0;
    #1;
    checkOutput("t6_busy", 64'(m_awvalid), 64'h1);
    m_wready = 1'b1;
    driveW(0, 32'h60, 1'b0);
    tick();
    driveW(0, 32'h61, 1'b0);
    tick();
    driveW(0, 32'h62, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_awvalid", 64'(m_awvalid), 64'h0);
    checkOutput("t6_rst_wready", 64'(s_wready), 64'h0);
    checkOutput("t6_rst_wvalid", 64'(m_wvalid), 64'h0);
    checkOutput("t6_rst_awaddr", m_awaddr, 64'h0);
    applyStimulus();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    driveAw(0, 16'h000B, 64'h7000, 8'd0);
    driveAw(1, 16'h000A, 64'h6000, 8'd0);
    s_awvalid = 2'b11;
    #1;
    checkOutput("t6_ptr_reset", 64'(s_awready), 64'h1);
    s_awvalid = 2'b10;
    #1;
    checkOutput("t6_p1_first", 64'(s_awready), 64'h2);
    tick();
    s_awvalid = '0;
    #1;
    checkOutput("t6_p1_tag", 64'(m_awid[15:14]), 64'h1);
    checkOutput("t6_p1_addr", m_awaddr, 64'h6000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
